// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the 5-stage hazard/forwarding controller: forwarding
// select encoding, per-stage shadow entry and the producer/consumer match.
package pipe_ctrl_pkg;

  localparam int RA_W_MAX = 8;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic                valid;
    logic [RA_W_MAX-1:0] rd;
    logic                reg_write;
    logic                is_load;
  } stage_info_t;

  localparam stage_info_t NO_STAGE = '{valid: 1'b0, rd: {RA_W_MAX{1'b0}},
                                       reg_write: 1'b0, is_load: 1'b0};

  // A register read hits a producer only for real writes to a non-hardwired register.
  function automatic logic stage_match(input stage_info_t s,
                                       input logic [RA_W_MAX-1:0] ra,
                                       input logic used,
                                       input logic zero_reg);
    return s.valid & s.reg_write & used & (s.rd == ra) &
           ~(zero_reg & (ra == {RA_W_MAX{1'b0}}));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Per-source forwarding comparator: picks the youngest eligible producer
// among MEM and WB, falling back to the register file.
module fwd_select
  import pipe_ctrl_pkg::*;
#(
  parameter bit ZERO_REG = 1'b0
) (
  input  stage_info_t         i_mem,
  input  stage_info_t         i_wb,
  input  logic [RA_W_MAX-1:0] i_ra,
  input  logic                i_used,
  output fwd_sel_t            o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = stage_match(i_mem, i_ra, i_used, ZERO_REG);
  assign w_wb_hit  = stage_match(i_wb, i_ra, i_used, ZERO_REG);

  // Load data is not available in MEM yet; the load-use bubble moves it to WB first.
  always_comb begin
    o_sel = FWD_RF;
    if (w_mem_hit && !i_mem.is_load) begin
      o_sel = FWD_MEM;
    end else if (w_wb_hit) begin
      o_sel = FWD_WB;
    end else begin
      o_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the IF/ID/EX/MEM/WB core: stage enables, flushes,
// EX forwarding selects, ID write-back bypass and stall/flush statistics.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RA_W     = 4,
  parameter int NSRC     = 3,
  parameter int CNT_W    = 32,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [NSRC*RA_W-1:0]   id_ra,
  input  logic [NSRC-1:0]        id_ra_used,
  input  logic [RA_W-1:0]        id_rd,
  input  logic                   id_reg_write,
  input  logic                   id_is_load,
  input  logic                   ex_branch_taken,
  input  logic                   mem_busy,
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   id_ex_en,
  output logic                   ex_mem_en,
  output logic                   mem_wb_en,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic [2*NSRC-1:0]      fwd_sel,
  output logic [NSRC-1:0]        id_wb_bypass,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       flush_cnt
);

  stage_info_t            r_ex;
  stage_info_t            r_mem;
  stage_info_t            r_wb;
  logic [NSRC*RA_W-1:0]   r_ex_ra;
  logic [NSRC-1:0]        r_ex_used;
  logic                   r_br_pend;
  logic [CNT_W-1:0]       r_stall_cnt;
  logic [CNT_W-1:0]       r_flush_cnt;

  stage_info_t            w_id_info;
  logic [NSRC-1:0]        w_lu_src;
  logic                   w_load_use;
  logic                   w_branch;
  logic                   w_stall_evt;
  logic                   w_flush_evt;

  assign w_id_info = '{valid: id_valid, rd: RA_W_MAX'(id_rd),
                       reg_write: id_reg_write, is_load: id_is_load};

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    logic [RA_W_MAX-1:0] w_ex_ra;
    logic [RA_W_MAX-1:0] w_id_ra;
    fwd_sel_t            w_ex_sel;
    fwd_sel_t            w_id_sel;

    assign w_ex_ra = RA_W_MAX'(r_ex_ra[g*RA_W +: RA_W]);
    assign w_id_ra = RA_W_MAX'(id_ra[g*RA_W +: RA_W]);

    fwd_select #(.ZERO_REG(ZERO_REG)) u_fwd_ex (
      .i_mem  (r_mem),
      .i_wb   (r_wb),
      .i_ra   (w_ex_ra),
      .i_used (r_ex_used[g]),
      .o_sel  (w_ex_sel)
    );

    // ID only cares about a same-cycle WB write, so MEM is masked off.
    fwd_select #(.ZERO_REG(ZERO_REG)) u_fwd_id (
      .i_mem  (NO_STAGE),
      .i_wb   (r_wb),
      .i_ra   (w_id_ra),
      .i_used (id_ra_used[g]),
      .o_sel  (w_id_sel)
    );

    assign w_lu_src[g]         = stage_match(r_ex, w_id_ra, id_ra_used[g], ZERO_REG);
    assign fwd_sel[2*g +: 2]   = rst ? FWD_RF : w_ex_sel;
    assign id_wb_bypass[g]     = ~rst & id_valid & (w_id_sel == FWD_WB);
  end

  assign w_load_use  = id_valid & r_ex.is_load & (|w_lu_src);
  assign w_branch    = ex_branch_taken | r_br_pend;
  assign w_stall_evt = mem_busy | (~w_branch & w_load_use);
  assign w_flush_evt = ~mem_busy & w_branch;

  // Enable/flush priority: reset, RAM freeze, taken branch, load-use, run.
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (mem_busy) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
    end else if (w_branch) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else begin
      pc_en       = 1'b1;
    end
  end

  // Shadow pipeline advance; everything holds while RAM is busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex      <= NO_STAGE;
      r_mem     <= NO_STAGE;
      r_wb      <= NO_STAGE;
      r_ex_ra   <= {(NSRC*RA_W){1'b0}};
      r_ex_used <= {NSRC{1'b0}};
    end else if (!mem_busy) begin
      r_ex      <= id_ex_flush ? NO_STAGE : w_id_info;
      r_ex_ra   <= id_ex_flush ? {(NSRC*RA_W){1'b0}} : id_ra;
      r_ex_used <= id_ex_flush ? {NSRC{1'b0}} : (id_ra_used & {NSRC{id_valid}});
      r_mem     <= r_ex;
      r_wb      <= r_mem;
    end
  end

  // A branch resolved during a freeze is remembered until the freeze lifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_pend <= 1'b0;
    end else if (mem_busy) begin
      r_br_pend <= r_br_pend | ex_branch_taken;
    end else begin
      r_br_pend <= 1'b0;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= {CNT_W{1'b0}};
      r_flush_cnt <= {CNT_W{1'b0}};
    end else begin
      if (w_stall_evt && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_flush_evt && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: instance A (ZERO_REG=0, 32-bit counters) and instance B
// (ZERO_REG=1, 4-bit counters) share stimulus; expectations are hand-computed.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [11:0] id_ra = 12'd0;
  logic [2:0]  id_ra_used = 3'd0;
  logic [3:0]  id_rd = 4'd0;
  logic        id_reg_write = 1'b0;
  logic        id_is_load = 1'b0;
  logic        ex_branch_taken = 1'b0;
  logic        mem_busy = 1'b0;

  logic        a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_iff, a_idf;
  logic [5:0]  a_fwd;
  logic [2:0]  a_byp;
  logic [31:0] a_stall, a_flush;
  logic        b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_iff, b_idf;
  logic [5:0]  b_fwd;
  logic [2:0]  b_byp;
  logic [3:0]  b_stall, b_flush;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.RA_W(4), .NSRC(3), .CNT_W(32), .ZERO_REG(1'b0)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_ra_used(id_ra_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_en(a_pc), .if_id_en(a_ifid), .id_ex_en(a_idex), .ex_mem_en(a_exmem),
    .mem_wb_en(a_memwb), .if_id_flush(a_iff), .id_ex_flush(a_idf),
    .fwd_sel(a_fwd), .id_wb_bypass(a_byp), .stall_cnt(a_stall), .flush_cnt(a_flush)
  );

  pipeline_hazard_ctrl #(.RA_W(4), .NSRC(3), .CNT_W(4), .ZERO_REG(1'b1)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_ra_used(id_ra_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_en(b_pc), .if_id_en(b_ifid), .id_ex_en(b_idex), .ex_mem_en(b_exmem),
    .mem_wb_en(b_memwb), .if_id_flush(b_iff), .id_ex_flush(b_idf),
    .fwd_sel(b_fwd), .id_wb_bypass(b_byp), .stall_cnt(b_stall), .flush_cnt(b_flush)
  );

  typedef struct {
    string      tag;
    logic [6:0] ef;
    logic [5:0] fa;
    logic [5:0] fb;
    logic [2:0] ba;
    logic [2:0] bb;
    int         st;
    int         fl;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
  localparam logic [6:0] RUN = 7'b11111_00;
  localparam logic [6:0] LU  = 7'b00111_01;
  localparam logic [6:0] BR  = 7'b11111_11;
  localparam logic [6:0] FZ  = 7'b00000_00;
  localparam logic [6:0] RS  = 7'b00000_11;

  task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s %s: got %0h expected %0h", tag, nm, act, exp);
    end
  endtask

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // Monitor: every negedge with a pending expectation compares both instances.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.tag, "A_en_flush", {25'd0, a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_iff, a_idf}, {25'd0, e.ef});
        chk(e.tag, "A_fwd_sel", {26'd0, a_fwd}, {26'd0, e.fa});
        chk(e.tag, "A_bypass", {29'd0, a_byp}, {29'd0, e.ba});
        chk(e.tag, "A_stall_cnt", a_stall, e.st);
        chk(e.tag, "A_flush_cnt", a_flush, e.fl);
        chk(e.tag, "B_en_flush", {25'd0, b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_iff, b_idf}, {25'd0, e.ef});
        chk(e.tag, "B_fwd_sel", {26'd0, b_fwd}, {26'd0, e.fb});
        chk(e.tag, "B_bypass", {29'd0, b_byp}, {29'd0, e.bb});
        chk(e.tag, "B_stall_cnt", {28'd0, b_stall}, sat15(e.st));
        chk(e.tag, "B_flush_cnt", {28'd0, b_flush}, sat15(e.fl));
      end
    end
  end

  task automatic cyc(input logic r, input logic v, input logic [3:0] a0, input logic [3:0] a1,
                     input logic [3:0] a2, input logic [2:0] u, input logic [3:0] rd,
                     input logic wr, input logic ld, input logic br, input logic busy,
                     input string tag, input logic [6:0] ef, input logic [5:0] fa,
                     input logic [5:0] fb, input logic [2:0] ba, input logic [2:0] bb,
                     input int st, input int fl);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_ra = {a2, a1, a0}; id_ra_used = u; id_rd = rd;
    id_reg_write = wr; id_is_load = ld; ex_branch_taken = br; mem_busy = busy;
    e.tag = tag; e.ef = ef; e.fa = fa; e.fb = fb; e.ba = ba; e.bb = bb; e.st = st; e.fl = fl;
    q.push_back(e);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, "rst_hold", RS, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, "rst_hold", RS, 0, 0, 0, 0, 0, 0);
    // ALU producer followed by dependent consumer: MEM forwarding, no stall
    cyc(0, 1, 3, 4, 0, 3'b011, 2, 1, 0, 0, 0, "t1_add", RUN, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 2, 1, 0, 3'b011, 7, 1, 0, 0, 0, "t1_sub_id", RUN, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, "t1_fwd_mem", RUN, 6'b000001, 6'b000001, 0, 0, 0, 0);
    // Load-use: one bubble, then WB forwarding
    cyc(0, 1, 1, 0, 0, 3'b001, 5, 1, 1, 0, 0, "t2_load", RUN, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 5, 1, 0, 3'b011, 6, 1, 0, 0, 0, "t2_loaduse", LU, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 5, 1, 0, 3'b011, 6, 1, 0, 0, 0, "t2_release", RUN, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, "t2_fwd_wb", RUN, 6'b000010, 6'b000010, 0, 0, 1, 0);
    // Taken branch overrides a simultaneous load-use hazard
    cyc(0, 1, 1, 0, 0, 3'b001, 8, 1, 1, 0, 0, "t3_load", RUN, 0, 0, 0, 0, 1, 0);
    cyc(0, 1, 8, 6, 0, 3'b011, 9, 1, 0, 1, 0, "t3_branch", BR, 0, 0, 3'b010, 3'b010, 1, 0);
    cyc(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, "t3_after", RUN, 0, 0, 0, 0, 1, 1);
    // RAM busy freeze with producer in MEM
    cyc(0, 1, 1, 0, 0, 3'b001, 10, 1, 0, 0, 0, "t4_prod", RUN, 0, 0, 0, 0, 1, 1);
    cyc(0, 1, 10, 2, 0, 3'b011, 11, 1, 0, 0, 0, "t4_cons", RUN, 0, 0, 0, 0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, "t4_freeze", FZ, 6'b000001, 6'b000001, 0, 0, 1 + k, 1);
    end
    cyc(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, "t4_resume", RUN, 6'b000001, 6'b000001, 0, 0, 4, 1);
    cyc(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 1, "t4_br_held", FZ, 0, 0, 0, 0, 4, 1);
    cyc(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, "t4_br_pend", BR, 0, 0, 0, 0, 5, 1);
    cyc(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, "t4_br_done", RUN, 0, 0, 0, 0, 5, 2);
    // Register 0: forwarded only when not hardwired zero
    cyc(0, 1, 1, 2, 0, 3'b011, 0, 1, 0, 0, 0, "t5_wr_r0", RUN, 0, 0, 0, 0, 5, 2);
    cyc(0, 1, 0, 0, 0, 3'b001, 3, 1, 0, 0, 0, "t5_rd_r0", RUN, 0, 0, 0, 0, 5, 2);
    cyc(0, 1, 0, 0, 0, 3'b001, 4, 1, 0, 0, 0, "t5_fwd_r0", RUN, 6'b000001, 0, 0, 0, 5, 2);
    cyc(0, 1, 0, 0, 0, 3'b001, 5, 0, 0, 0, 0, "t5_byp_r0", RUN, 6'b000010, 0, 3'b001, 0, 5, 2);
    // Reset in the middle of a load-use stall
    cyc(0, 1, 1, 0, 0, 3'b001, 12, 1, 1, 0, 0, "t6_load", RUN, 0, 0, 0, 0, 5, 2);
    cyc(0, 1, 12, 0, 0, 3'b001, 13, 1, 0, 0, 0, "t6_loaduse", LU, 0, 0, 0, 0, 5, 2);
    cyc(1, 1, 12, 0, 0, 3'b001, 13, 1, 0, 0, 0, "t6_rst_mid", RS, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 12, 0, 0, 3'b001, 13, 1, 0, 0, 0, "t6_post_rst", RUN, 0, 0, 0, 0, 0, 0);
    // 20 freeze cycles: 4-bit counter saturates at 15
    for (int k = 0; k < 20; k++) begin
      cyc(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, "sat_freeze", FZ, 0, 0, 0, 0, k, 0);
    end
    cyc(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, "sat_final", RUN, 0, 0, 0, 0, 20, 0);
    @(negedge clk);
    @(negedge clk);
    chk("end", "scoreboard_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
